// File: rtl/rob_pkg.sv
// rob_pkg: shared widths and completion-source encoding for the ROB completion path
package rob_pkg;
  localparam int IDX_W = 4;
  localparam int VAL_W = 32;
  localparam int EXC_W = 3;
  typedef enum logic [1:0] {
    SRC_ALU   = 2'd0,
    SRC_CACHE = 2'd1,
    SRC_MUL   = 2'd2
  } src_e;
endpackage

// File: rtl/rr_arbiter3.sv
// rr_arbiter3: 3-way grant, round-robin when ROB_CMPL_RR_EN is defined, else fixed CACHE > MUL > ALU
module rr_arbiter3 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [2:0] req,
  output logic [2:0] gnt
);
  import rob_pkg::*;
`ifdef ROB_CMPL_RR_EN
  src_e       ptr_q, ptr_d;
  logic [2:0] rot, rot_gnt;
  // rotate requests so the pointed-to source is checked first, pick, rotate back
  always_comb begin
    rot     = ptr_q == SRC_CACHE ? {req[0], req[2:1]} : ptr_q == SRC_MUL ? {req[1:0], req[2]} : req;
    rot_gnt = rot[0] ? 3'b001 : rot[1] ? 3'b010 : rot[2] ? 3'b100 : 3'b000;
    gnt     = ptr_q == SRC_CACHE ? {rot_gnt[1:0], rot_gnt[2]} : ptr_q == SRC_MUL ? {rot_gnt[0], rot_gnt[2:1]} : rot_gnt;
  end
  // pointer moves to the source after the one actually granted; a flushed grant does not count
  always_comb begin
    ptr_d = (en && |gnt) ? (gnt[SRC_ALU] ? SRC_CACHE : gnt[SRC_CACHE] ? SRC_MUL : SRC_ALU) : ptr_q;
  end
  // pointer register
  always_ff @(posedge clk) begin
    ptr_q <= reset ? SRC_ALU : ptr_d;
  end
`else
  logic unused_ok;
  assign unused_ok = ^{clk, reset, en};
  // fixed priority, no state
  always_comb begin
    gnt = req[SRC_CACHE] ? 3'b010 : req[SRC_MUL] ? 3'b100 : req[SRC_ALU] ? 3'b001 : 3'b000;
  end
`endif
endmodule

// File: rtl/rob_complete_arbiter.sv
// rob_complete_arbiter: merges ALU/CACHE/MUL completions into one ROB strobe (ROB_CMPL_RR_EN selects round-robin)
module rob_complete_arbiter #(
  parameter int IDX_W = rob_pkg::IDX_W,
  parameter int VAL_W = rob_pkg::VAL_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_flush,
  input  logic                      in_alu_valid,
  input  logic [IDX_W-1:0]          in_alu_idx,
  input  logic [VAL_W-1:0]          in_alu_value,
  input  logic [rob_pkg::EXC_W-1:0] in_alu_exception,
  input  logic                      in_cache_valid,
  input  logic [IDX_W-1:0]          in_cache_idx,
  input  logic [VAL_W-1:0]          in_cache_value,
  input  logic [rob_pkg::EXC_W-1:0] in_cache_exception,
  input  logic                      in_mul_valid,
  input  logic [IDX_W-1:0]          in_mul_idx,
  input  logic [VAL_W-1:0]          in_mul_value,
  input  logic [rob_pkg::EXC_W-1:0] in_mul_exception,
  output logic                      out_alu_ready,
  output logic                      out_cache_ready,
  output logic                      out_mul_ready,
  output logic                      out_complete,
  output logic [IDX_W-1:0]          out_complete_idx,
  output logic [VAL_W-1:0]          out_complete_value,
  output logic [rob_pkg::EXC_W-1:0] out_complete_exception
);
  import rob_pkg::*;
  logic [2:0]       in_valid, rdy, gnt, pend_q, pend_d;
  logic [IDX_W-1:0] in_idx [3], idx_q [3], idx_d [3];
  logic [VAL_W-1:0] in_val [3], val_q [3], val_d [3];
  logic [EXC_W-1:0] in_exc [3], exc_q [3], exc_d [3];
  logic             cmp_q, cmp_d, fire;
  logic [IDX_W-1:0] oidx_q, oidx_d;
  logic [VAL_W-1:0] oval_q, oval_d;
  logic [EXC_W-1:0] oexc_q, oexc_d;
  src_e             sel;
  rr_arbiter3 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (!in_flush),
    .req   (pend_q),
    .gnt   (gnt)
  );
  // gather per-source offers into source-indexed arrays
  always_comb begin
    in_valid = {in_mul_valid, in_cache_valid, in_alu_valid};
    in_idx[SRC_ALU]   = in_alu_idx;
    in_idx[SRC_CACHE] = in_cache_idx;
    in_idx[SRC_MUL]   = in_mul_idx;
    in_val[SRC_ALU]   = in_alu_value;
    in_val[SRC_CACHE] = in_cache_value;
    in_val[SRC_MUL]   = in_mul_value;
    in_exc[SRC_ALU]   = in_alu_exception;
    in_exc[SRC_CACHE] = in_cache_exception;
    in_exc[SRC_MUL]   = in_mul_exception;
  end
  assign rdy             = {3{!reset && !in_flush}} & (~pend_q | gnt);
  assign out_alu_ready   = rdy[SRC_ALU];
  assign out_cache_ready = rdy[SRC_CACHE];
  assign out_mul_ready   = rdy[SRC_MUL];
  // a slot loads on handshake (reloading in the same cycle it is granted) and empties on grant or flush
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      pend_d[i] = !in_flush && ((in_valid[i] && rdy[i]) || (pend_q[i] && !gnt[i]));
      idx_d[i]  = (in_valid[i] && rdy[i]) ? in_idx[i] : idx_q[i];
      val_d[i]  = (in_valid[i] && rdy[i]) ? in_val[i] : val_q[i];
      exc_d[i]  = (in_valid[i] && rdy[i]) ? in_exc[i] : exc_q[i];
    end
  end
  // copy the granted slot to the output registers; payload holds when nothing is sent
  always_comb begin
    sel    = gnt[SRC_CACHE] ? SRC_CACHE : gnt[SRC_MUL] ? SRC_MUL : SRC_ALU;
    fire   = !in_flush && |gnt;
    cmp_d  = fire;
    oidx_d = fire ? idx_q[sel] : oidx_q;
    oval_d = fire ? val_q[sel] : oval_q;
    oexc_d = fire ? exc_q[sel] : oexc_q;
  end
  // slot and output state; only valid bits and outputs need reset, slot payload is don't-care when empty
  always_ff @(posedge clk) begin
    pend_q <= reset ? 3'b000 : pend_d;
    idx_q  <= idx_d;
    val_q  <= val_d;
    exc_q  <= exc_d;
    cmp_q  <= reset ? 1'b0 : cmp_d;
    oidx_q <= reset ? '0 : oidx_d;
    oval_q <= reset ? '0 : oval_d;
    oexc_q <= reset ? '0 : oexc_d;
  end
  assign out_complete           = cmp_q;
  assign out_complete_idx       = oidx_q;
  assign out_complete_value     = oval_q;
  assign out_complete_exception = oexc_q;
endmodule

// File: tb/tb_rob_complete_arbiter.sv
// tb_rob_complete_arbiter: directed checks of the completion arbiter in the build's arbitration mode
module tb_rob_complete_arbiter;
  logic        clk = 0, reset, in_flush;
  logic        in_alu_valid, in_cache_valid, in_mul_valid;
  logic [3:0]  in_alu_idx, in_cache_idx, in_mul_idx;
  logic [31:0] in_alu_value, in_cache_value, in_mul_value;
  logic [2:0]  in_alu_exception, in_cache_exception, in_mul_exception;
  logic        out_alu_ready, out_cache_ready, out_mul_ready, out_complete;
  logic [3:0]  out_complete_idx;
  logic [31:0] out_complete_value;
  logic [2:0]  out_complete_exception;
  int n_chk = 0, n_fail = 0;
  int na, nc, ea, ec;
  logic [3:0]  e_idx [3];
  logic [31:0] e_val [3];
  logic [2:0]  e_rdy6, e_rdy7;
  logic [3:0]  e_first;
  rob_complete_arbiter dut (
    .clk(clk), .reset(reset), .in_flush(in_flush),
    .in_alu_valid(in_alu_valid), .in_alu_idx(in_alu_idx), .in_alu_value(in_alu_value), .in_alu_exception(in_alu_exception),
    .in_cache_valid(in_cache_valid), .in_cache_idx(in_cache_idx), .in_cache_value(in_cache_value), .in_cache_exception(in_cache_exception),
    .in_mul_valid(in_mul_valid), .in_mul_idx(in_mul_idx), .in_mul_value(in_mul_value), .in_mul_exception(in_mul_exception),
    .out_alu_ready(out_alu_ready), .out_cache_ready(out_cache_ready), .out_mul_ready(out_mul_ready),
    .out_complete(out_complete), .out_complete_idx(out_complete_idx),
    .out_complete_value(out_complete_value), .out_complete_exception(out_complete_exception)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    in_flush = 0;
    in_alu_valid = 0; in_cache_valid = 0; in_mul_valid = 0;
    in_alu_idx = 0; in_cache_idx = 0; in_mul_idx = 0;
    in_alu_value = 0; in_cache_value = 0; in_mul_value = 0;
    in_alu_exception = 0; in_cache_exception = 0; in_mul_exception = 0;
  endtask
  task automatic offer3();
    in_alu_valid = 1;   in_alu_idx = 4'd1;   in_alu_value = 32'hA1;   in_alu_exception = 3'd1;
    in_cache_valid = 1; in_cache_idx = 4'd2; in_cache_value = 32'hC2; in_cache_exception = 3'd2;
    in_mul_valid = 1;   in_mul_idx = 4'd3;   in_mul_value = 32'hD3;   in_mul_exception = 3'd3;
  endtask
  task automatic rcv();
    if (out_complete) begin
      if (out_complete_value[11:8] == 4'h1) begin
        chk("ord_alu", out_complete_value, 32'h100 + ea);
        ea++;
      end else begin
        chk("ord_cache", out_complete_value, 32'h200 + ec);
        ec++;
      end
    end
  endtask
  initial begin
`ifdef ROB_CMPL_RR_EN
    e_idx = '{4'd1, 4'd2, 4'd3}; e_val = '{32'hA1, 32'hC2, 32'hD3};
    e_rdy6 = 3'b001; e_rdy7 = 3'b011; e_first = 4'd1;
`else
    e_idx = '{4'd2, 4'd3, 4'd1}; e_val = '{32'hC2, 32'hD3, 32'hA1};
    e_rdy6 = 3'b010; e_rdy7 = 3'b110; e_first = 4'd2;
`endif
    clr();
    reset = 1;
    offer3();
    repeat (2) tick();
    chk("rst_rdy", {out_mul_ready, out_cache_ready, out_alu_ready}, 3'b000);
    chk("rst_cmp", out_complete, 0);
    chk("rst_idx", out_complete_idx, 0);
    chk("rst_val", out_complete_value, 0);
    chk("rst_exc", out_complete_exception, 0);
    clr();
    reset = 0;
    tick();
    offer3();
    #1;
    chk("all_rdy5", {out_mul_ready, out_cache_ready, out_alu_ready}, 3'b111);
    tick();
    clr();
    #1;
    chk("rdy6", {out_mul_ready, out_cache_ready, out_alu_ready}, e_rdy6);
    chk("cmp6", out_complete, 0);
    tick();
    chk("rdy7", {out_mul_ready, out_cache_ready, out_alu_ready}, e_rdy7);
    for (int k = 0; k < 3; k++) begin
      chk("order_cmp", out_complete, 1);
      chk("order_idx", out_complete_idx, e_idx[k]);
      chk("order_val", out_complete_value, e_val[k]);
      tick();
    end
    chk("order_done", out_complete, 0);
    in_alu_valid = 1; in_alu_idx = 4'd3; in_alu_value = 32'h11; in_alu_exception = 3'd0;
    #1;
    chk("alu_rdy", out_alu_ready, 1);
    tick();
    clr();
    #1;
    chk("alu_lat1", out_complete, 0);
    tick();
    chk("alu_cmp", out_complete, 1);
    chk("alu_idx", out_complete_idx, 3);
    chk("alu_val", out_complete_value, 32'h11);
    chk("alu_exc", out_complete_exception, 0);
    tick();
    chk("alu_off", out_complete, 0);
    chk("alu_hold", out_complete_idx, 3);
    chk("alu_holdv", out_complete_value, 32'h11);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        in_alu_valid = 1; in_alu_idx = 4'(4 + i); in_alu_value = 32'h40 + i; in_alu_exception = 3'(i);
      end else clr();
      #1;
      if (i < 4) chk("b2b_rdy", out_alu_ready, 1);
      if (i >= 2) begin
        chk("b2b_cmp", out_complete, 1);
        chk("b2b_idx", out_complete_idx, 4'(4 + i - 2));
        chk("b2b_val", out_complete_value, 32'h40 + i - 2);
      end
      tick();
    end
    chk("b2b_end", out_complete, 0);
    na = 0; nc = 0; ea = 0; ec = 0;
    for (int c = 0; c < 20; c++) begin
      if (c < 12) begin
        in_alu_valid = 1;   in_alu_idx = 4'(na);   in_alu_value = 32'h100 + na;
        in_cache_valid = 1; in_cache_idx = 4'(nc); in_cache_value = 32'h200 + nc;
      end else clr();
      #1;
      rcv();
      if (in_alu_valid && out_alu_ready) na++;
      if (in_cache_valid && out_cache_ready) nc++;
      tick();
    end
    chk("alu_cnt", ea, na);
    chk("cache_cnt", ec, nc);
`ifdef ROB_CMPL_RR_EN
    chk("alu_fair", na >= 5, 1);
`endif
    offer3();
    tick();
    clr();
    tick();
    in_flush = 1;
    in_alu_valid = 1; in_alu_idx = 4'd5; in_alu_value = 32'h55;
    #1;
    chk("fl_cmp", out_complete, 1);
    chk("fl_rdy", {out_mul_ready, out_cache_ready, out_alu_ready}, 3'b000);
    tick();
    clr();
    for (int i = 0; i < 4; i++) begin
      chk("fl_quiet", out_complete, 0);
      tick();
    end
    in_alu_valid = 1; in_alu_idx = 4'd9; in_alu_value = 32'h99;
    tick();
    clr();
    tick();
    chk("fl_new_cmp", out_complete, 1);
    chk("fl_new_idx", out_complete_idx, 9);
    chk("fl_new_val", out_complete_value, 32'h99);
    tick();
    offer3();
    tick();
    clr();
    reset = 1;
    tick();
    chk("mr_cmp", out_complete, 0);
    chk("mr_idx", out_complete_idx, 0);
    chk("mr_val", out_complete_value, 0);
    chk("mr_exc", out_complete_exception, 0);
    reset = 0;
    tick();
    chk("mr_q1", out_complete, 0);
    tick();
    chk("mr_q2", out_complete, 0);
    offer3();
    tick();
    clr();
    tick();
    chk("mr_first_cmp", out_complete, 1);
    chk("mr_first_idx", out_complete_idx, e_first);
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
